// File: rtl/transmissor_sensores_pkg.sv
// Shared definitions for the reactor-side transmitter and control-room deserializer.
// Thresholds, frame geometry, transmitter FSM states and the alarm rule.
package pacote_usina;

    localparam int unsigned TEMP_LIM     = 40;
    localparam int unsigned PRESS_LIM    = 7;
    localparam int unsigned RAD_LIM      = 1000;
    localparam int unsigned FRAME_BITS   = 28;
    localparam int unsigned PAYLOAD_BITS = 25;

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARIDADE,
        PARADA
    } estado_tx_t;

    // Unsigned alarm rule shared by both ends of the link.
    function automatic logic calc_alarme(
        input logic [7:0]  t,
        input logic [3:0]  p,
        input logic [11:0] r,
        input int unsigned tl,
        input int unsigned pl,
        input int unsigned rl
    );
        return (32'(t) > tl) | (32'(p) >= pl) | (32'(r) >= rl);
    endfunction

endpackage

// File: rtl/transmissor_sensores_gerador_baud.sv
// Baud counter: wraps at BAUD_DIV-1 and flags that cycle with a tick.
// Clear forces the count back to the start of a bit period.
module gerador_baud #(
    parameter int BAUD_DIV = 16,
    localparam int CW = $clog2(BAUD_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CW'(BAUD_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/transmissor_sensores.sv
// Reactor-side serial transmitter: latches the sensor buses on request and
// sends start, 25 payload bits, even parity and stop, LSB first.
module transmissor_sensores #(
    parameter int          BAUD_DIV  = 16,
    parameter int unsigned TEMP_LIM  = pacote_usina::TEMP_LIM,
    parameter int unsigned PRESS_LIM = pacote_usina::PRESS_LIM,
    parameter int unsigned RAD_LIM   = pacote_usina::RAD_LIM
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  temp,
    input  logic [3:0]  pressao,
    input  logic [11:0] radiacao,
    input  logic        enviar,
    output logic        tx,
    output logic        ocupado,
    output logic        quadroEnviado,
    output logic        alarmeLocal
);

    import pacote_usina::*;

    estado_tx_t              estado_q;
    logic                    tx_q;
    logic                    ocupado_q;
    logic                    quadro_q;
    logic                    alarme_q;
    logic [23:0]             sombra_q;
    logic                    flag_q;
    logic                    paridade_q;
    logic [4:0]              idx_q;

    logic                    aceita_d;
    logic                    alarme_d;
    logic                    paridade_d;
    logic [4:0]              prox_idx_d;
    logic [PAYLOAD_BITS-1:0] carga_d;
    logic                    tick;

    assign aceita_d   = enviar && !ocupado_q;
    assign alarme_d   = calc_alarme(temp, pressao, radiacao,
                                    TEMP_LIM, PRESS_LIM, RAD_LIM);
    assign paridade_d = ^{alarme_d, radiacao, pressao, temp};
    assign prox_idx_d = idx_q + 5'd1;
    assign carga_d    = {flag_q, sombra_q};

    gerador_baud #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr_i (aceita_d),
        .en_i  (ocupado_q),
        .tick_o(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            tx_q       <= 1'b1;
            ocupado_q  <= 1'b0;
            quadro_q   <= 1'b0;
            alarme_q   <= 1'b0;
            sombra_q   <= '0;
            flag_q     <= 1'b0;
            paridade_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            alarme_q <= alarme_d;
            quadro_q <= 1'b0;
            unique case (estado_q)
                OCIOSO: begin
                    tx_q <= 1'b1;
                    if (aceita_d) begin
                        sombra_q   <= {radiacao, pressao, temp};
                        flag_q     <= alarme_d;
                        paridade_q <= paridade_d;
                        idx_q      <= '0;
                        tx_q       <= 1'b0;
                        ocupado_q  <= 1'b1;
                        estado_q   <= INICIO;
                    end
                end
                INICIO: begin
                    if (tick) begin
                        tx_q     <= carga_d[0];
                        idx_q    <= '0;
                        estado_q <= DADOS;
                    end
                end
                DADOS: begin
                    if (tick) begin
                        if (idx_q == 5'(PAYLOAD_BITS - 1)) begin
                            tx_q     <= paridade_q;
                            estado_q <= PARIDADE;
                        end else begin
                            idx_q <= prox_idx_d;
                            tx_q  <= carga_d[prox_idx_d];
                        end
                    end
                end
                PARIDADE: begin
                    if (tick) begin
                        tx_q     <= 1'b1;
                        estado_q <= PARADA;
                    end
                end
                PARADA: begin
                    // Stop bit done: free the line in the same cycle as the pulse.
                    if (tick) begin
                        quadro_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                        estado_q  <= OCIOSO;
                    end
                end
                default: begin
                    tx_q      <= 1'b1;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign tx            = tx_q;
    assign ocupado       = ocupado_q;
    assign quadroEnviado = quadro_q;
    assign alarmeLocal   = alarme_q;

endmodule

// File: tb/tb_transmissor_sensores.sv
// Randomized bench for transmissor_sensores with BAUD_DIV=4 against a
// frame-level reference model (frame vector indexed by elapsed cycles).
module tb_transmissor_sensores;

    localparam int BD = 4;
    localparam int FB = 28;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enviar = 1'b0;
    logic [7:0]  temp = '0;
    logic [3:0]  pressao = '0;
    logic [11:0] radiacao = '0;
    logic        tx;
    logic        ocupado;
    logic        quadroEnviado;
    logic        alarmeLocal;

    int checks = 0;
    int failures = 0;
    int npulsos = 0;

    bit          m_busy = 0;
    int          m_cnt = 0;
    logic [27:0] m_fr = '0;
    logic        m_q = 0;
    logic        m_al = 0;

    transmissor_sensores #(
        .BAUD_DIV(BD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .temp         (temp),
        .pressao      (pressao),
        .radiacao     (radiacao),
        .enviar       (enviar),
        .tx           (tx),
        .ocupado      (ocupado),
        .quadroEnviado(quadroEnviado),
        .alarmeLocal  (alarmeLocal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic alarme_ref(input int t, input int p, input int r);
        return (t > 40) || (p >= 7) || (r >= 1000);
    endfunction

    function automatic logic [27:0] monta(input logic [7:0] t,
                                          input logic [3:0] p,
                                          input logic [11:0] r);
        logic al;
        logic par;
        al  = alarme_ref(int'(t), int'(p), int'(r));
        par = ($countones({al, r, p, t}) % 2) != 0;
        return {1'b1, par, al, r, p, t, 1'b0};
    endfunction

    task automatic modelo();
        m_al = rst ? 1'b0 : alarme_ref(int'(temp), int'(pressao), int'(radiacao));
        m_q  = 1'b0;
        if (rst) begin
            m_busy = 0;
            m_cnt  = 0;
        end else if (m_busy) begin
            m_cnt++;
            if (m_cnt == FB * BD) begin
                m_busy = 0;
                m_q    = 1'b1;
            end
        end else if (enviar) begin
            m_busy = 1;
            m_cnt  = 0;
            m_fr   = monta(temp, pressao, radiacao);
        end
    endtask

    task automatic ciclo();
        logic etx;
        @(posedge clk);
        modelo();
        @(negedge clk);
        etx = m_busy ? m_fr[m_cnt / BD] : 1'b1;
        chk("tx", 32'(tx), 32'(etx));
        chk("ocupado", 32'(ocupado), 32'(m_busy));
        chk("quadroEnviado", 32'(quadroEnviado), 32'(m_q));
        chk("alarmeLocal", 32'(alarmeLocal), 32'(m_al));
        if (quadroEnviado) npulsos++;
    endtask

    task automatic sorteia();
        temp     = 8'($urandom_range(0, 1) != 0 ? $urandom_range(35, 45) : $urandom);
        pressao  = 4'($urandom);
        radiacao = 12'($urandom_range(0, 1) != 0 ? $urandom_range(995, 1005) : $urandom);
    endtask

    initial begin
        repeat (3) ciclo();
        rst = 1'b0;
        repeat (5) ciclo();

        temp = 8'h29; pressao = 4'h3; radiacao = 12'h0F0;
        enviar = 1'b1;
        npulsos = 0;
        ciclo();
        enviar = 1'b0;
        repeat (FB * BD + 5) ciclo();
        chk("pulsos_quadro_dirigido", 32'(npulsos), 32'd1);

        temp = 8'd40; pressao = 4'd6; radiacao = 12'd999;
        repeat (2) ciclo();
        chk("alarme_limite_baixo", 32'(alarmeLocal), 32'd0);
        pressao = 4'd7;
        ciclo();
        chk("alarme_pressao", 32'(alarmeLocal), 32'd1);

        enviar = 1'b1;
        npulsos = 0;
        for (int i = 0; i < 3 * FB * BD + 4; i++) begin
            if (i % 13 == 0) sorteia();
            ciclo();
        end
        enviar = 1'b0;
        repeat (FB * BD) ciclo();
        chk("pulsos_continuos", 32'(npulsos), 32'd4);

        sorteia();
        enviar = 1'b1;
        ciclo();
        enviar = 1'b0;
        npulsos = 0;
        repeat (10 * BD + 1) ciclo();
        enviar = 1'b1;
        ciclo();
        enviar = 1'b0;
        repeat (FB * BD + 4) ciclo();
        chk("pulso_unico", 32'(npulsos), 32'd1);

        sorteia();
        enviar = 1'b1;
        ciclo();
        enviar = 1'b0;
        npulsos = 0;
        repeat (15 * BD + 1) ciclo();
        rst = 1'b1;
        ciclo();
        rst = 1'b0;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_ocupado", 32'(ocupado), 32'd0);
        repeat (FB * BD) ciclo();
        chk("abort_sem_pulso", 32'(npulsos), 32'd0);
        sorteia();
        enviar = 1'b1;
        ciclo();
        enviar = 1'b0;
        repeat (FB * BD + 2) ciclo();
        chk("quadro_pos_abort", 32'(npulsos), 32'd1);

        repeat (2500) begin
            enviar = ($urandom_range(0, 19) == 0);
            rst    = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 7) == 0) sorteia();
            ciclo();
        end
        rst = 1'b0;
        enviar = 1'b0;
        repeat (FB * BD + 2) ciclo();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
